// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs BEATS entries into one valid/ready word.
// Optional per-lane parity output when PACKER_PARITY_EN is defined.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int BEATS      = 4
) (
    input  logic                        rd_clk,
    input  logic                        rd_rst,
    input  logic                        fifo_empty,
    input  logic [DATA_WIDTH-1:0]       fifo_data_out,
    output logic                        fifo_rd_en,
    input  logic                        flush,
    output logic [DATA_WIDTH*BEATS-1:0] out_data,
    output logic [BEATS-1:0]            out_keep,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef PACKER_PARITY_EN
    ,
    output logic [BEATS-1:0]            out_parity
`endif
);

    localparam int CW = $clog2(BEATS + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          pend;
    logic          flush_req;
    logic [CW:0]   inflight;
    logic          handshake;
    logic          last_land;

    assign inflight  = {1'b0, cnt} + (CW + 1)'(pend);
    assign handshake = out_valid && out_ready;
    assign last_land = pend && (cnt == CW'(BEATS - 1));

    assign fifo_rd_en = rd_rst
                     && (state == FILL)
                     && !fifo_empty
                     && !flush_req
                     && (inflight < (CW + 1)'(BEATS));

    // A completing landing outranks a same-cycle flush: the word is full anyway.
    always_comb begin
        state_nx = state;
        unique case (state)
            FILL: begin
                if (last_land)
                    state_nx = SEND;
                else if (flush && ((cnt != '0) || pend))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (!pend)
                    state_nx = (cnt != '0) ? SEND : FILL;
            end
            SEND: begin
                if (handshake)
                    state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            state     <= FILL;
            cnt       <= '0;
            pend      <= 1'b0;
            flush_req <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
`ifdef PACKER_PARITY_EN
            out_parity <= '0;
`endif
        end else begin
            state     <= state_nx;
            pend      <= fifo_rd_en;
            out_valid <= (state_nx == SEND);

            if ((state == FILL) && (state_nx == DRAIN))
                flush_req <= 1'b1;
            else if ((state == DRAIN) && (state_nx == FILL))
                flush_req <= 1'b0;

            if (handshake) begin
                cnt       <= '0;
                out_keep  <= '0;
                flush_req <= 1'b0;
`ifdef PACKER_PARITY_EN
                out_parity <= '0;
`endif
            end else if (pend) begin
                cnt <= cnt + CW'(1);
                for (int k = 0; k < BEATS; k++) begin
                    if (cnt == CW'(k)) begin
                        out_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_data_out;
                        out_keep[k] <= 1'b1;
`ifdef PACKER_PARITY_EN
                        out_parity[k] <= ^fifo_data_out;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO model plus in-order scoreboard.
// Directed scenarios followed by a randomized traffic phase.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int WW = DW * NB;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic [WW-1:0] out_data;
    logic [NB-1:0] out_keep;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef PACKER_PARITY_EN
    logic [NB-1:0] out_parity;
    logic [NB-1:0] last_par = '0;
`endif

    fifo_rd_packer #(.DATA_WIDTH(DW), .BEATS(NB)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef PACKER_PARITY_EN
        ,
        .out_parity   (out_parity)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] rdq[$];
    int            reads = 0;
    int            hs = 0;
    int            cyc_n = 0;
    int            last_hs_cyc = 0;
    int            hs_gap = 0;
    logic [WW-1:0] last_data = '0;
    logic [NB-1:0] last_keep = '0;
    bit            flush_seen = 0;
    bit            prev_stall = 0;
    logic [WW-1:0] prev_data = '0;
    logic [NB-1:0] prev_keep = '0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc_n);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        flush_seen = 1;
    endtask

    // Word-level checks: an emitted word is the next run of entries read.
    task automatic on_handshake();
        int n;
        logic [DW-1:0] e;
        logic [NB-1:0] pexp;
        n = $countones(out_keep);
        pexp = '0;
        check("keep_contig", 64'(out_keep), (64'(1) << n) - 64'(1));
        check("keep_nonempty", 64'(n != 0), 64'(1));
        if (!flush_seen)
            check("keep_full", 64'(n), 64'(NB));
        check("sb_depth", 64'(rdq.size() >= n), 64'(1));
        for (int k = 0; k < n; k++) begin
            if (rdq.size() != 0) begin
                e = rdq.pop_front();
                pexp[k] = ^e;
                check("lane", 64'(out_data[k*DW +: DW]), 64'(e));
            end
        end
`ifdef PACKER_PARITY_EN
        check("parity", 64'(out_parity), 64'(pexp));
        last_par = out_parity;
`endif
        hs_gap = cyc_n - last_hs_cyc;
        last_hs_cyc = cyc_n;
        hs++;
        last_data = out_data;
        last_keep = out_keep;
        flush_seen = 0;
    endtask

    task automatic cyc();
        logic en;
        logic rst_s;
        @(negedge rd_clk);
        en = fifo_rd_en;
        rst_s = rd_rst;
        if (!rd_rst) begin
            check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
            prev_stall = 0;
        end else begin
            if (out_valid)
                check("rd_en_send", 64'(fifo_rd_en), 64'(0));
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_keep", 64'(out_keep), 64'(prev_keep));
            end
            if (out_valid && out_ready)
                on_handshake();
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
        end
        @(posedge rd_clk);
        #1;
        if (!rst_s)
            rdq.delete();
        if (en) begin
            if (fq.size() != 0) begin
                fifo_data_out = fq.pop_front();
                rdq.push_back(fifo_data_out);
            end
            reads++;
        end
        fifo_empty = (fq.size() == 0);
        cyc_n++;
        flush = 1'b0;
    endtask

    int r0;
    int h0;
    int guard;
    logic [DW-1:0] v[8];

    initial begin
        rd_rst = 1'b0;
        repeat (3) cyc();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_keep", 64'(out_keep), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        rd_rst = 1'b1;
        out_ready = 1'b1;
        cyc();

        // Full packing
        r0 = reads; h0 = hs;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (12) cyc();
        check("pack_reads", 64'(reads - r0), 64'(4));
        check("pack_words", 64'(hs - h0), 64'(1));
        check("pack_data", 64'(last_data), 64'h44332211);
        check("pack_keep", 64'(last_keep), 64'hf);

        // Backpressure
        out_ready = 1'b0;
        r0 = reads; h0 = hs;
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        repeat (10) cyc();
        check("bp_valid", 64'(out_valid), 64'(1));
        check("bp_data", 64'(out_data), 64'h44332211);
        check("bp_reads", 64'(reads - r0), 64'(4));
        out_ready = 1'b1;
        repeat (16) cyc();
        check("bp_words", 64'(hs - h0), 64'(2));
        check("bp_data2", 64'(last_data), 64'h88776655);

        // Throughput with a pre-loaded FIFO
        h0 = hs;
        for (int i = 0; i < 12; i++) push(8'($urandom));
        for (int i = 0; i < 30; i++) begin
            r0 = hs;
            cyc();
            if (hs != r0 && hs - h0 >= 2)
                check("throughput", 64'(hs_gap), 64'(NB + 2));
        end
        check("tp_words", 64'(hs - h0), 64'(3));

        // Flush of a partial word, then flush with nothing held
        h0 = hs;
        push(8'hA1); push(8'hA2);
        repeat (6) cyc();
        check("fl_idle", 64'(out_valid), 64'(0));
        pulse_flush();
        repeat (8) cyc();
        check("fl_words", 64'(hs - h0), 64'(1));
        check("fl_data", 64'(last_data[15:0]), 64'hA2A1);
        check("fl_keep", 64'(last_keep), 64'h3);
        h0 = hs;
        pulse_flush();
        repeat (8) cyc();
        check("fl_empty_words", 64'(hs - h0), 64'(0));
        check("fl_empty_valid", 64'(out_valid), 64'(0));

        // FIFO runs dry mid-word
        h0 = hs; r0 = reads;
        for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
        push(v[0]); push(v[1]); push(v[2]);
        repeat (10) cyc();
        check("st_valid", 64'(out_valid), 64'(0));
        check("st_rd_en", 64'(fifo_rd_en), 64'(0));
        check("st_reads", 64'(reads - r0), 64'(3));
        push(v[3]);
        repeat (8) cyc();
        check("st_words", 64'(hs - h0), 64'(1));
        check("st_keep", 64'(last_keep), 64'hf);
        check("st_data", 64'(last_data), 64'({v[3], v[2], v[1], v[0]}));

        // Parity lanes
        push(8'h01); push(8'h03); push(8'h07); push(8'h00);
        repeat (10) cyc();
        check("par_data", 64'(last_data), 64'h00070301);
`ifdef PACKER_PARITY_EN
        check("par_bits", 64'(last_par), 64'h5);
`endif

        // Reset with two lanes landed and a third read in flight
        for (int i = 0; i < 8; i++) begin
            v[i] = 8'($urandom);
            push(v[i]);
        end
        r0 = reads; guard = 0;
        while (reads - r0 < 3 && guard < 20) begin
            cyc();
            guard++;
        end
        check("rmw_reads", 64'(reads - r0), 64'(3));
        rd_rst = 1'b0;
        cyc();
        check("rmw_valid", 64'(out_valid), 64'(0));
        check("rmw_keep", 64'(out_keep), 64'(0));
        check("rmw_data", 64'(out_data), 64'(0));
        check("rmw_noread", 64'(reads - r0), 64'(3));
        rd_rst = 1'b1;
        h0 = hs;
        repeat (12) cyc();
        check("rmw_words", 64'(hs - h0), 64'(1));
        check("rmw_word", 64'(last_data), 64'({v[6], v[5], v[4], v[3]}));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0 && fq.size() < 16)
                push(8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0)
                pulse_flush();
            cyc();
        end

        out_ready = 1'b1;
        repeat (12) cyc();
        pulse_flush();
        repeat (12) cyc();
        check("end_fifo", 64'(fq.size()), 64'(0));
        check("end_sb", 64'(rdq.size()), 64'(0));
        check("end_valid", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
